// File: rtl/sift_pkg.sv
// Shared SIFT package: word/address/count widths and readout FSM encoding.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package sift_pkg;

  // One matched-memory word, its address width and the keypoint-count width.
  localparam int SIFT_DATA_W = 49;
  localparam int SIFT_ADDR_W = 9;
  localparam int SIFT_CNT_W  = 11;

  // Matched-memory readout FSM encoding.
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FETCH = 3'd1,
    ST_LATCH = 3'd2,
    ST_EMIT  = 3'd3,
    ST_FIN   = 3'd4
  } rd_state_e;

endpackage

// File: rtl/match_readout.sv
// Drains kpt_num entries from four banked matched memories as a valid/ready stream.
// Latency: first out_valid 3 cycles after start; 2 bubble cycles between 4-entry groups.
// Backpressure: out_ready low holds out_data/out_index/out_last stable; no entry is dropped.
//
// Ports:
//   clk, rst_n             clock, asynchronous active-low reset
//   start, kpt_num         one-cycle drain request and entry count (sampled in IDLE only)
//   matched_addr_2         read address shared by the four banks (0 outside FETCH)
//   matched_dout2_0..3     bank read data, valid one cycle after the address
//   out_valid/out_ready    entry handshake; out_data, out_index, out_last describe the entry
//   busy, done             FSM not idle; one-cycle completion pulse
module match_readout
  import sift_pkg::*;
#(
  parameter int DATA_W = SIFT_DATA_W,
  parameter int ADDR_W = SIFT_ADDR_W,
  parameter int CNT_W  = SIFT_CNT_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [CNT_W-1:0]  kpt_num,
  output logic [ADDR_W-1:0] matched_addr_2,
  input  logic [DATA_W-1:0] matched_dout2_0,
  input  logic [DATA_W-1:0] matched_dout2_1,
  input  logic [DATA_W-1:0] matched_dout2_2,
  input  logic [DATA_W-1:0] matched_dout2_3,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CNT_W-1:0]  out_index,
  output logic              out_last,
  output logic              busy,
  output logic              done
);

  rd_state_e         state, state_nxt;
  logic [CNT_W-1:0]  k;        // current entry number
  logic [CNT_W-1:0]  cnt;      // latched kpt_num for this drain
  logic [DATA_W-1:0] grp_0, grp_1, grp_2, grp_3;
  logic [DATA_W-1:0] bank_dat;
  logic              is_last;

  assign is_last = (k == cnt - CNT_W'(1));

  // Entry k lives at address k>>2, bank k[1:0].
  always_comb begin
    bank_dat = grp_0;
    case (k[1:0])
      2'd1:    bank_dat = grp_1;
      2'd2:    bank_dat = grp_2;
      2'd3:    bank_dat = grp_3;
      default: bank_dat = grp_0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt      = state;
    matched_addr_2 = '0;
    out_valid      = 1'b0;
    out_data       = '0;
    out_index      = '0;
    out_last       = 1'b0;
    busy           = 1'b1;
    done           = 1'b0;
    case (state)
      ST_IDLE: begin
        busy = 1'b0;
        if (start) begin
          state_nxt = (kpt_num == '0) ? ST_FIN : ST_FETCH;
        end
      end
      ST_FETCH: begin
        matched_addr_2 = k[ADDR_W+1:2];
        state_nxt      = ST_LATCH;
      end
      ST_LATCH: begin
        state_nxt = ST_EMIT;
      end
      ST_EMIT: begin
        out_valid = 1'b1;
        out_data  = bank_dat;
        out_index = k;
        out_last  = is_last;
        if (out_ready) begin
          // A partial last group ends here too, so unused banks are never shown.
          if (is_last) begin
            state_nxt = ST_FIN;
          end else if (k[1:0] == 2'd3) begin
            state_nxt = ST_FETCH;
          end
        end
      end
      ST_FIN: begin
        done      = 1'b1;
        state_nxt = ST_IDLE;
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  // Datapath: count latch, entry counter and group registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      k     <= '0;
      cnt   <= '0;
      grp_0 <= '0;
      grp_1 <= '0;
      grp_2 <= '0;
      grp_3 <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          // start is only honoured here, so a start while busy leaves cnt alone.
          if (start) begin
            cnt <= kpt_num;
            k   <= '0;
          end
        end
        ST_LATCH: begin
          grp_0 <= matched_dout2_0;
          grp_1 <= matched_dout2_1;
          grp_2 <= matched_dout2_2;
          grp_3 <= matched_dout2_3;
        end
        ST_EMIT: begin
          if (out_ready) begin
            k <= k + CNT_W'(1);
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_match_readout.sv
// Bench for match_readout: banked memory model, entry scoreboard and timing model.
// Latency: n/a.
// Backpressure: out_ready patterns are generated by the bench.
module tb_match_readout;

  localparam int DW = 49;
  localparam int AW = 9;
  localparam int CW = 11;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic [CW-1:0] kpt_num;
  logic [AW-1:0] matched_addr_2;
  logic [DW-1:0] d0, d1, d2, d3;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic [DW-1:0] out_data;
  logic [CW-1:0] out_index;
  logic          out_last;
  logic          busy;
  logic          done;

  always #5 clk = ~clk;

  match_readout dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .start           (start),
    .kpt_num         (kpt_num),
    .matched_addr_2  (matched_addr_2),
    .matched_dout2_0 (d0),
    .matched_dout2_1 (d1),
    .matched_dout2_2 (d2),
    .matched_dout2_3 (d3),
    .out_valid       (out_valid),
    .out_ready       (out_ready),
    .out_data        (out_data),
    .out_index       (out_index),
    .out_last        (out_last),
    .busy            (busy),
    .done            (done)
  );

  // Memory content encodes its own bank and address so misrouting is visible.
  function automatic logic [DW-1:0] word(input int b, input int a);
    logic [1:0] bb;
    logic [8:0] aa;
    bb = b[1:0];
    aa = a[8:0];
    return {bb, aa, 38'h12345678};
  endfunction

  // Four synchronous-read banks, one cycle of latency.
  always @(posedge clk) begin
    d0 <= word(0, int'(matched_addr_2));
    d1 <= word(1, int'(matched_addr_2));
    d2 <= word(2, int'(matched_addr_2));
    d3 <= word(3, int'(matched_addr_2));
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h, want %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  typedef struct {
    int            idx;
    logic [DW-1:0] dat;
    bit            last;
  } ent_t;

  // Model state, written only by the monitor.
  ent_t          exp_q[$];
  int            fetch_log[$];
  bit            run_active = 0;
  bit            head_seen  = 0;
  bit            in_gap     = 0;
  int            busy_from, next_due, done_due, run_start, done_cyc;
  int            busy_cnt, idx2_cnt, last_idx;
  logic [DW-1:0] last_dat;

  always @(negedge clk) begin : mon
    ent_t e;
    int   n;
    if (!rst_n) begin
      chk("rst_outs", {out_valid, out_last, busy, done, |out_data, |out_index, |matched_addr_2}, 0);
      exp_q.delete();
      run_active = 0;
      head_seen  = 0;
      in_gap     = 0;
    end else begin
      if (start && !run_active) begin
        n          = int'(kpt_num);
        run_active = 1;
        run_start  = cyc;
        busy_from  = cyc + 1;
        next_due   = cyc + 3;
        done_due   = cyc + 1;
        done_cyc   = -1;
        head_seen  = 0;
        in_gap     = 0;
        busy_cnt   = 0;
        idx2_cnt   = 0;
        fetch_log.delete();
        exp_q.delete();
        for (int k = 0; k < n; k++) begin
          exp_q.push_back('{k, word(k % 4, k / 4), (k == n - 1)});
        end
      end

      chk("busy", busy, (run_active && cyc >= busy_from));
      if (run_active && busy) busy_cnt++;

      // Non-emitting busy cycles come in address/latch pairs.
      if (busy && !out_valid && !done) begin
        if (!in_gap) begin
          fetch_log.push_back(int'(matched_addr_2));
          in_gap = 1;
        end else begin
          chk("addr_latch", matched_addr_2, 0);
          in_gap = 0;
        end
      end else begin
        in_gap = 0;
        chk("addr_idle", matched_addr_2, 0);
      end

      if (out_valid) begin
        if (out_index == 2) idx2_cnt++;
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_valid: index %0d presented, none outstanding (cycle %0d)", out_index, cyc);
        end else begin
          e = exp_q[0];
          if (!head_seen) begin
            chk("valid_time", cyc, next_due);
            head_seen = 1;
          end
          chk("index", out_index, e.idx);
          chk("data", out_data, e.dat);
          chk("last", out_last, e.last);
          if (out_ready) begin
            void'(exp_q.pop_front());
            head_seen = 0;
            if (e.last) begin
              done_due = cyc + 1;
              last_dat = out_data;
              last_idx = int'(out_index);
            end else begin
              next_due = cyc + ((e.idx % 4 == 3) ? 3 : 1);
            end
          end
        end
      end else if (head_seen) begin
        checks++;
        errors++;
        $display("FAIL valid_dropped: entry %0d withdrawn before acceptance (cycle %0d)", exp_q[0].idx, cyc);
        head_seen = 0;
      end

      if (done) begin
        checks++;
        if (!(run_active && exp_q.size() == 0 && cyc == done_due)) begin
          errors++;
          $display("FAIL done_pulse: got done at cycle %0d, want cycle %0d with run active=%0d pending=%0d",
                   cyc, done_due, run_active, exp_q.size());
        end
        done_cyc   = cyc;
        run_active = 0;
      end
    end
  end

  // out_ready patterns: 0 always ready, 1 stall entry 2 for 5 cycles, 2 stall on entry 6.
  int rdy_mode   = 0;
  int stall_left = 5;
  always @(posedge clk) begin
    #1;
    case (rdy_mode)
      0: begin
        out_ready  = 1'b1;
        stall_left = 5;
      end
      1: begin
        if (out_valid && out_index == 2 && stall_left > 0) begin
          out_ready = 1'b0;
          stall_left--;
        end else begin
          out_ready = 1'b1;
        end
      end
      default: out_ready = !(out_valid && out_index == 6);
    endcase
  end

  task automatic pulse_start(input int n);
    @(posedge clk);
    #1;
    start   = 1'b1;
    kpt_num = n[CW-1:0];
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic wait_idle(input int lim, input string nm);
    int i;
    i = 0;
    @(negedge clk);
    #1;
    while (run_active && i < lim) begin
      @(negedge clk);
      #1;
      i++;
    end
    if (run_active) begin
      checks++;
      errors++;
      $display("FAIL timeout_%s: drain still active after %0d cycles", nm, lim);
    end
  endtask

  task automatic wait_entry(input int idx, input string nm);
    bit found;
    found = 0;
    for (int i = 0; i < 100 && !found; i++) begin
      @(negedge clk);
      #1;
      if (out_valid && out_index == idx) found = 1;
    end
    chk(nm, found, 1);
  endtask

  task automatic end_run(input int n, input int done_off, input string nm);
    int bad;
    bad = -1;
    chk({nm, "_fetch_count"}, fetch_log.size(), (n + 3) / 4);
    foreach (fetch_log[i]) if (bad < 0 && fetch_log[i] != i) bad = i;
    chk({nm, "_fetch_addr_first_bad"}, bad, -1);
    chk({nm, "_done_offset"}, done_cyc - run_start, done_off);
    @(negedge clk);
    #1;
    chk({nm, "_idle_after"}, {busy, done, out_valid}, 0);
  endtask

  initial begin : watchdog
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n   = 1'b0;
    start   = 1'b0;
    kpt_num = '0;
    #1;
    chk("por_valid", out_valid, 0);
    chk("por_busy_done", {busy, done}, 0);
    chk("por_addr", matched_addr_2, 0);
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Eight entries, sink always ready: groups at S+3..S+6 and S+9..S+12.
    rdy_mode = 0;
    pulse_start(8);
    wait_idle(200, "n8");
    end_run(8, 13, "n8");
    chk("n8_last_idx", last_idx, 7);

    // Partial final group: entry 4 comes from bank 0 of address 1.
    pulse_start(5);
    wait_idle(200, "n5");
    end_run(5, 10, "n5");
    chk("n5_last_idx", last_idx, 4);
    chk("n5_last_dat", last_dat, 49'h40_1234_5678);

    // Empty drain: straight to completion.
    pulse_start(0);
    wait_idle(50, "n0");
    end_run(0, 1, "n0");
    chk("n0_busy_cycles", busy_cnt, 1);

    // Sink stalls 5 cycles on entry 2.
    rdy_mode = 1;
    pulse_start(8);
    wait_idle(200, "stall");
    end_run(8, 18, "stall");
    chk("stall_idx2_cycles", idx2_cnt, 6);
    rdy_mode = 0;

    // A second start mid-drain must be ignored.
    pulse_start(8);
    wait_entry(2, "ign_reach_idx2");
    pulse_start(3);
    wait_idle(200, "ignore");
    end_run(8, 13, "ignore");
    chk("ignore_last_idx", last_idx, 7);

    // Asynchronous reset while entry 6 is presented.
    rdy_mode = 2;
    pulse_start(8);
    wait_entry(6, "rst_reach_idx6");
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_valid", out_valid, 0);
    chk("arst_data", out_data, 0);
    chk("arst_index", out_index, 0);
    chk("arst_last", out_last, 0);
    chk("arst_busy", busy, 0);
    chk("arst_done", done, 0);
    chk("arst_addr", matched_addr_2, 0);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n    = 1'b1;
    rdy_mode = 0;
    repeat (3) @(negedge clk);

    // Full-size drain after reset restarts from entry 0.
    pulse_start(2047);
    wait_idle(4000, "n2047");
    end_run(2047, 3072, "n2047");
    chk("n2047_last_idx", last_idx, 2046);
    chk("n2047_last_dat", last_dat, 49'h1_7FC0_1234_5678);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
